// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter: FSM state
// encodings, grant owner identifiers, abort data word and counter width.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_IF   = 2'd1,
      S_DM   = 2'd2
   } arb_state_e;

   typedef enum logic {
      GNT_IF = 1'b0,
      GNT_DM = 1'b1
   } grant_e;

   localparam logic [31:0] ERR_WORD = 32'hDEADBEEF;
   localparam int          CNT_W    = 8;

endpackage

// File: rtl/mem_port_arbiter_timer.sv
// Per-transaction wait counter. Cleared on grant and on every exit from a
// wait state, so it never wraps; expired_o flags the last allowed wait cycle.
module mem_arb_timer
   import mem_port_arbiter_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic inc_i,
   output logic expired_o
);

   logic [CNT_W-1:0] cnt_q;

   // Count wait cycles; clear has priority over increment.
   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (inc_i) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign expired_o = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// Registered grant FSM with alternating priority under contention, a
// per-transaction timeout that returns ERR_WORD with bus_err, and a
// combinational stall that holds the pipeline while a requester waits.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_req,
   input  logic [AW-1:0]   if_addr,
   output logic            if_ack,
   output logic [DW-1:0]   if_rdata,
   input  logic            dm_req,
   input  logic            dm_we,
   input  logic [DW/8-1:0] dm_be,
   input  logic [AW-1:0]   dm_addr,
   input  logic [DW-1:0]   dm_wdata,
   output logic            dm_ack,
   output logic [DW-1:0]   dm_rdata,
   output logic            mem_req,
   output logic            mem_we,
   output logic [DW/8-1:0] mem_be,
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_wdata,
   input  logic [DW-1:0]   mem_rdata,
   input  logic            mem_ack,
   output logic            stall,
   output logic            bus_err
);

   localparam int BW = DW / 8;

   arb_state_e      state_q, state_d;
   grant_e          last_grant_q, last_grant_d;
   logic            mem_req_q, mem_req_d;
   logic            mem_we_q, mem_we_d;
   logic [BW-1:0]   mem_be_q, mem_be_d;
   logic [AW-1:0]   mem_addr_q, mem_addr_d;
   logic [DW-1:0]   mem_wdata_q, mem_wdata_d;

   logic            tmr_clr, tmr_inc, expired;
   logic            in_wait, done, timed_out;
   logic [DW-1:0]   rsp_data;

   mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (tmr_clr),
      .inc_i     (tmr_inc),
      .expired_o (expired)
   );

   // State, grant history and the registered memory command.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         last_grant_q <= GNT_IF;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_be_q     <= '0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_be_q     <= mem_be_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
      end
   end

   // Next-state: grant from IDLE (alternating on contention), finish a
   // wait on memory ack or on timeout, otherwise keep counting.
   // NOTE: every signal gets its default first so no path infers a latch.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_be_d     = mem_be_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      tmr_clr      = 1'b0;
      tmr_inc      = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (dm_req && (!if_req || last_grant_q == GNT_IF)) begin
               state_d      = S_DM;
               last_grant_d = GNT_DM;
               mem_req_d    = 1'b1;
               mem_we_d     = dm_we;
               mem_be_d     = dm_be;
               mem_addr_d   = dm_addr;
               mem_wdata_d  = dm_wdata;
               tmr_clr      = 1'b1;
            end else if (if_req) begin
               state_d      = S_IF;
               last_grant_d = GNT_IF;
               mem_req_d    = 1'b1;
               mem_we_d     = 1'b0;
               mem_be_d     = '1;
               mem_addr_d   = if_addr;
               mem_wdata_d  = '0;
               tmr_clr      = 1'b1;
            end
         end
         S_IF, S_DM: begin
            if (mem_ack || expired) begin
               state_d   = S_IDLE;
               mem_req_d = 1'b0;
               tmr_clr   = 1'b1;
            end else begin
               tmr_inc   = 1'b1;
            end
         end
         default: begin
            state_d   = S_IDLE;
            mem_req_d = 1'b0;
            tmr_clr   = 1'b1;
         end
      endcase
   end

   // Completion decode: memory ack beats the timeout in the same cycle.
   always_comb begin
      in_wait   = (state_q == S_IF) || (state_q == S_DM);
      done      = in_wait && (mem_ack || expired);
      timed_out = in_wait && !mem_ack && expired;
      rsp_data  = mem_ack ? mem_rdata : DW'(ERR_WORD);
      if_ack    = done && (state_q == S_IF);
      dm_ack    = done && (state_q == S_DM);
      if_rdata  = if_ack ? rsp_data : '0;
      dm_rdata  = dm_ack ? rsp_data : '0;
      bus_err   = timed_out;
      stall     = (if_req && !if_ack) || (dm_req && !dm_ack);
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_be    = mem_be_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with TIMEOUT=4. Inputs change 2 time
// units after the rising edge; outputs are compared 1 unit later.
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_ack;
   logic [DW-1:0] if_rdata;
   logic          dm_req;
   logic          dm_we;
   logic [3:0]    dm_be;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_wdata;
   logic          dm_ack;
   logic [DW-1:0] dm_rdata;
   logic          mem_req;
   logic          mem_we;
   logic [3:0]    mem_be;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ack;
   logic          stall;
   logic          bus_err;

   int n_vec  = 0;
   int n_miss = 0;

   mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_ack    (if_ack),
      .if_rdata  (if_rdata),
      .dm_req    (dm_req),
      .dm_we     (dm_we),
      .dm_be     (dm_be),
      .dm_addr   (dm_addr),
      .dm_wdata  (dm_wdata),
      .dm_ack    (dm_ack),
      .dm_rdata  (dm_rdata),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_be    (mem_be),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .stall     (stall),
      .bus_err   (bus_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, " if_ack"},  64'(if_ack),   64'd0);
      check({tag, " dm_ack"},  64'(dm_ack),   64'd0);
      check({tag, " bus_err"}, 64'(bus_err),  64'd0);
      check({tag, " if_rd"},   64'(if_rdata), 64'd0);
      check({tag, " dm_rd"},   64'(dm_rdata), 64'd0);
   endtask

   initial begin
      rst = 1'b1; if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_be = '0;
      dm_addr = '0; dm_wdata = '0; mem_rdata = '0; mem_ack = 0;

      // Reset state
      tick(); tick();
      check("rst mem_req",   64'(mem_req),   64'd0);
      check("rst mem_we",    64'(mem_we),    64'd0);
      check("rst mem_be",    64'(mem_be),    64'd0);
      check("rst mem_addr",  64'(mem_addr),  64'd0);
      check("rst mem_wdata", 64'(mem_wdata), 64'd0);
      check("rst stall",     64'(stall),     64'd0);
      check_idle_outputs("rst");
      rst = 1'b0;

      // mem_ack in IDLE is ignored
      tick();
      mem_ack = 1; mem_rdata = 32'h11111111;
      #1;
      check_idle_outputs("idle ack");
      tick();
      mem_ack = 0;
      #1;
      check("idle ack mem_req", 64'(mem_req), 64'd0);

      // Lone fetch, 1-cycle memory
      if_req = 1; if_addr = 32'h0040_0000;
      #1;
      check("lf stall pre",   64'(stall),   64'd1);
      check("lf mem_req pre", 64'(mem_req), 64'd0);
      tick();
      check("lf mem_req",  64'(mem_req),  64'd1);
      check("lf mem_we",   64'(mem_we),   64'd0);
      check("lf mem_be",   64'(mem_be),   64'hF);
      check("lf mem_addr", 64'(mem_addr), 64'h0040_0000);
      mem_ack = 1; mem_rdata = 32'h2408_000A;
      #1;
      check("lf if_ack",   64'(if_ack),   64'd1);
      check("lf if_rdata", 64'(if_rdata), 64'h2408_000A);
      check("lf stall",    64'(stall),    64'd0);
      check("lf bus_err",  64'(bus_err),  64'd0);
      check("lf dm_ack",   64'(dm_ack),   64'd0);
      tick();
      if_req = 0; mem_ack = 0;
      #1;
      check("lf mem_req post", 64'(mem_req), 64'd0);
      check_idle_outputs("lf post");

      // Contention right after reset: DM first
      rst = 1'b1; tick(); rst = 1'b0;
      if_req = 1; if_addr = 32'h0040_0004;
      dm_req = 1; dm_we = 1; dm_be = 4'hF; dm_addr = 32'h1001_0000; dm_wdata = 32'h1234_5678;
      tick();
      check("ct mem_req",   64'(mem_req),   64'd1);
      check("ct mem_we",    64'(mem_we),    64'd1);
      check("ct mem_addr",  64'(mem_addr),  64'h1001_0000);
      check("ct mem_wdata", 64'(mem_wdata), 64'h1234_5678);
      check("ct mem_be",    64'(mem_be),    64'hF);
      mem_ack = 1; mem_rdata = 32'h0;
      #1;
      check("ct dm_ack", 64'(dm_ack), 64'd1);
      check("ct if_ack", 64'(if_ack), 64'd0);
      check("ct stall",  64'(stall),  64'd1);
      tick();
      dm_req = 0; mem_ack = 0;
      #1;
      check("ct gap mem_req", 64'(mem_req), 64'd0);
      check("ct gap if_ack",  64'(if_ack),  64'd0);
      tick();
      check("ct if mem_req",  64'(mem_req),  64'd1);
      check("ct if mem_addr", 64'(mem_addr), 64'h0040_0004);
      check("ct if mem_we",   64'(mem_we),   64'd0);
      mem_ack = 1; mem_rdata = 32'h8C08_0000;
      #1;
      check("ct if_ack",   64'(if_ack),   64'd1);
      check("ct if_rdata", 64'(if_rdata), 64'h8C08_0000);
      tick();
      if_req = 0; mem_ack = 0;

      // Alternation: both held for 6 transactions, last grant was IF
      if_req = 1; if_addr = 32'h0040_0100;
      dm_req = 1; dm_we = 0; dm_be = 4'h3; dm_addr = 32'h1001_0200;
      for (int i = 0; i < 6; i++) begin
         automatic logic exp_dm = (i % 2 == 0);
         tick();
         check($sformatf("alt%0d mem_req", i), 64'(mem_req), 64'd1);
         check($sformatf("alt%0d mem_addr", i), 64'(mem_addr),
               exp_dm ? 64'h1001_0200 : 64'h0040_0100);
         mem_ack = 1; mem_rdata = 32'hA000_0000 + 32'(i);
         #1;
         check($sformatf("alt%0d dm_ack", i), 64'(dm_ack), 64'(exp_dm));
         check($sformatf("alt%0d if_ack", i), 64'(if_ack), 64'(!exp_dm));
         tick();
         mem_ack = 0;
         #1;
         check($sformatf("alt%0d gap", i), 64'(mem_req), 64'd0);
      end
      if_req = 0; dm_req = 0;

      // Timeout on a DM load, TIMEOUT=4
      dm_req = 1; dm_we = 0; dm_be = 4'hF; dm_addr = 32'h1001_0040;
      for (int w = 1; w <= 3; w++) begin
         tick();
         check($sformatf("to w%0d mem_req", w), 64'(mem_req), 64'd1);
         check($sformatf("to w%0d dm_ack", w),  64'(dm_ack),  64'd0);
         check($sformatf("to w%0d bus_err", w), 64'(bus_err), 64'd0);
      end
      tick();
      check("to dm_ack",   64'(dm_ack),   64'd1);
      check("to dm_rdata", 64'(dm_rdata), 64'hDEAD_BEEF);
      check("to bus_err",  64'(bus_err),  64'd1);
      check("to stall",    64'(stall),    64'd0);
      tick();
      dm_req = 0;
      #1;
      check("to mem_req post", 64'(mem_req), 64'd0);
      check_idle_outputs("to post");

      // mem_ack coincides with the deadline: real data wins
      if_req = 1; if_addr = 32'h0040_0200;
      tick(); tick(); tick();
      check("dl w3 if_ack", 64'(if_ack), 64'd0);
      tick();
      mem_ack = 1; mem_rdata = 32'hCAFE_F00D;
      #1;
      check("dl if_ack",   64'(if_ack),   64'd1);
      check("dl if_rdata", 64'(if_rdata), 64'hCAFE_F00D);
      check("dl bus_err",  64'(bus_err),  64'd0);
      tick();
      if_req = 0; mem_ack = 0;
      #1;
      check("dl mem_req post", 64'(mem_req), 64'd0);

      // Async reset in the middle of DM_WAIT
      dm_req = 1; dm_we = 1; dm_be = 4'h1; dm_addr = 32'h1001_0080; dm_wdata = 32'h55;
      tick();
      check("ar mem_req before", 64'(mem_req), 64'd1);
      #1 rst = 1'b1;
      #1;
      check("ar mem_req",  64'(mem_req),  64'd0);
      check("ar mem_addr", 64'(mem_addr), 64'd0);
      check("ar mem_we",   64'(mem_we),   64'd0);
      check_idle_outputs("ar");
      mem_ack = 1;
      tick();
      check_idle_outputs("ar held");
      rst = 1'b0; mem_ack = 0; dm_req = 0;
      tick();
      if_req = 1; if_addr = 32'h0040_0300;
      dm_req = 1; dm_we = 0; dm_addr = 32'h1001_00C0;
      tick();
      check("ar regrant addr", 64'(mem_addr), 64'h1001_00C0);
      mem_ack = 1;
      #1;
      check("ar regrant dm_ack", 64'(dm_ack), 64'd1);
      tick();
      mem_ack = 0; if_req = 0; dm_req = 0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
